id_rename: RTL and testbench

ID_RENAME -- requirements
Module: id_rename

---
 rtl/scipio_pkg.sv | 19 +
 rtl/rename_table.sv | 106 ++++++++++
 rtl/id_rename.sv | 183 ++++++++++++++++++
 tb/tb_id_rename.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scipio_pkg.sv
// Shared decode-stage constants: operation/unit widths, execution units and
// the reserved "value ready" ROB tag.
package scipio_pkg;

  localparam int OP_W      = 4;
  localparam int UNIT_W    = 2;
  localparam int NUM_UNITS = 4;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_LSU = 2'd2,
    UNIT_ERR = 2'd3
  } unit_e;

  localparam logic [UNIT_W-1:0] EX_ERR_UNIT = UNIT_ERR;
  localparam int TAG_INVALID = 0;

endpackage

// File: rtl/rename_table.sv
// Register status (busy ROB tag) and architectural value arrays with two
// bypassing read ports, one rename write port and one commit port.
module rename_table
  import scipio_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int TAG_W    = 4,
  parameter  int WB_PORTS = 2,
  localparam int RW       = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [1:0][RW-1:0]         rs_i,
  output logic [1:0][TAG_W-1:0]      tag_o,
  output logic [1:0][XLEN-1:0]       val_o,
  output logic [1:0][XLEN-1:0]       arch_o,
  input  logic                       ren_en_i,
  input  logic [RW-1:0]              ren_rd_i,
  input  logic [TAG_W-1:0]           ren_tag_i,
  input  logic [WB_PORTS-1:0]        wb_valid_i,
  input  logic [WB_PORTS*TAG_W-1:0]  wb_tag_i,
  input  logic [WB_PORTS*XLEN-1:0]   wb_val_i,
  input  logic                       cm_valid_i,
  input  logic [RW-1:0]              cm_rd_i,
  input  logic [TAG_W-1:0]           cm_tag_i,
  input  logic [XLEN-1:0]            cm_val_i
);

  logic [NREG-1:0][TAG_W-1:0] status_q, status_d;
  logic [NREG-1:0][XLEN-1:0]  arch_q, arch_d;
  logic [1:0][TAG_W-1:0]      busy_s;
  logic [1:0]                 wb_hit_s;
  logic [1:0][XLEN-1:0]       wb_hit_val_s;

  // Lookup: a busy tag resolves from a same-cycle broadcast first, then commit
  always_comb begin
    busy_s       = '0;
    wb_hit_s     = '0;
    wb_hit_val_s = '0;
    tag_o        = '0;
    val_o        = '0;
    arch_o       = '0;
    for (int r = 0; r < 2; r++) begin
      busy_s[r] = (rs_i[r] == '0) ? TAG_W'(TAG_INVALID) : status_q[rs_i[r]];
      arch_o[r] = arch_q[rs_i[r]];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p] && (wb_tag_i[p*TAG_W +: TAG_W] == busy_s[r])) begin
          wb_hit_s[r]     = 1'b1;
          wb_hit_val_s[r] = wb_val_i[p*XLEN +: XLEN];
        end else begin
          wb_hit_s[r] = wb_hit_s[r];
        end
      end
      if (busy_s[r] == TAG_W'(TAG_INVALID)) begin
        tag_o[r] = TAG_W'(TAG_INVALID);
        val_o[r] = arch_q[rs_i[r]];
      end else if (wb_hit_s[r]) begin
        tag_o[r] = TAG_W'(TAG_INVALID);
        val_o[r] = wb_hit_val_s[r];
      end else if (cm_valid_i && (cm_rd_i == rs_i[r]) && (cm_tag_i == busy_s[r])) begin
        tag_o[r] = TAG_W'(TAG_INVALID);
        val_o[r] = cm_val_i;
      end else begin
        tag_o[r] = busy_s[r];
        val_o[r] = arch_q[rs_i[r]];
      end
    end
  end

  // Commit clears only its own tag; a same-cycle rename of that register wins
  always_comb begin
    status_d = status_q;
    arch_d   = arch_q;
    if (cm_valid_i && (cm_rd_i != '0)) begin
      arch_d[cm_rd_i] = cm_val_i;
      if ((status_q[cm_rd_i] == cm_tag_i) && !(ren_en_i && (ren_rd_i == cm_rd_i))) begin
        status_d[cm_rd_i] = TAG_W'(TAG_INVALID);
      end else begin
        status_d[cm_rd_i] = status_q[cm_rd_i];
      end
    end else begin
      arch_d = arch_q;
    end
    if (flush_i) begin
      status_d = '0;
    end else if (ren_en_i && (ren_rd_i != '0)) begin
      status_d[ren_rd_i] = ren_tag_i;
    end else begin
      status_d = status_d;
    end
  end

  // Table state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q <= '0;
      arch_q   <= '0;
    end else begin
      status_q <= status_d;
      arch_q   <= arch_d;
    end
  end

endmodule

// File: rtl/id_rename.sv
// Decode-to-dispatch rename stage: allocates ROB tags to destinations and
// resolves source operands into ready values or pending producer tags.
module id_rename
  import scipio_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int TAG_W    = 4,
  parameter  int WB_PORTS = 2,
  localparam int RW       = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [OP_W-1:0]           in_op,
  input  logic [UNIT_W-1:0]         in_unit,
  input  logic [RW-1:0]             in_rs1,
  input  logic [RW-1:0]             in_rs2,
  input  logic [RW-1:0]             in_rd,
  input  logic                      in_rs1_en,
  input  logic                      in_rs2_en,
  input  logic                      in_rd_en,
  input  logic                      in_imm_en,
  input  logic                      in_pc_en,
  input  logic                      rob_ready,
  input  logic [TAG_W-1:0]          rob_tag,
  output logic                      rob_alloc,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
  input  logic [WB_PORTS*XLEN-1:0]  wb_val,
  input  logic                      cm_valid,
  input  logic [RW-1:0]             cm_rd,
  input  logic [TAG_W-1:0]          cm_tag,
  input  logic [XLEN-1:0]           cm_val,
  input  logic [NUM_UNITS-1:0]      rs_full,
  output logic                      out_valid,
  output logic [OP_W-1:0]           out_op,
  output logic [UNIT_W-1:0]         out_unit,
  output logic [TAG_W-1:0]          out_tag1,
  output logic [TAG_W-1:0]          out_tag2,
  output logic [XLEN-1:0]           out_val1,
  output logic [XLEN-1:0]           out_val2,
  output logic [TAG_W-1:0]          out_target
);

  logic                out_valid_q, out_valid_d;
  logic [OP_W-1:0]     out_op_q, out_op_d;
  logic [UNIT_W-1:0]   out_unit_q, out_unit_d;
  logic [TAG_W-1:0]    out_tag1_q, out_tag1_d, out_tag2_q, out_tag2_d;
  logic [XLEN-1:0]     out_val1_q, out_val1_d, out_val2_q, out_val2_d;
  logic [TAG_W-1:0]    out_target_q, out_target_d;

  logic                fire_s, dispatch_s, rename_s;
  logic [1:0][TAG_W-1:0] tbl_tag_s;
  logic [1:0][XLEN-1:0]  tbl_val_s, tbl_arch_s;
  logic [TAG_W-1:0]    tag1_s, tag2_s;
  logic [XLEN-1:0]     val1_s, val2_s;

  assign in_ready   = rst & rob_ready & ~rs_full[in_unit] & ~flush &
                      (~out_valid_q | ~rs_full[out_unit_q]);
  assign fire_s     = in_valid & in_ready;
  assign dispatch_s = fire_s & (in_unit != EX_ERR_UNIT);
  assign rename_s   = dispatch_s & in_rd_en;
  assign rob_alloc  = dispatch_s;

  rename_table #(
    .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .WB_PORTS(WB_PORTS)
  ) u_table (
    .clk(clk), .rst(rst), .flush_i(flush),
    .rs_i({in_rs2, in_rs1}), .tag_o(tbl_tag_s), .val_o(tbl_val_s), .arch_o(tbl_arch_s),
    .ren_en_i(rename_s), .ren_rd_i(in_rd), .ren_tag_i(rob_tag),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_val_i(wb_val),
    .cm_valid_i(cm_valid), .cm_rd_i(cm_rd), .cm_tag_i(cm_tag), .cm_val_i(cm_val)
  );

  // Operand select: pc/immediate, unused or x0 source, else renamed lookup
  always_comb begin
    tag1_s = tbl_tag_s[0];
    val1_s = tbl_val_s[0];
    tag2_s = tbl_tag_s[1];
    val2_s = tbl_val_s[1];
    if (in_pc_en) begin
      tag1_s = TAG_W'(TAG_INVALID);
      val1_s = in_pc;
    end else if (!in_rs1_en || (in_rs1 == '0)) begin
      tag1_s = TAG_W'(TAG_INVALID);
      val1_s = tbl_arch_s[0];
    end else begin
      tag1_s = tbl_tag_s[0];
    end
    if (in_imm_en) begin
      tag2_s = TAG_W'(TAG_INVALID);
      val2_s = in_imm;
    end else if (!in_rs2_en || (in_rs2 == '0)) begin
      tag2_s = TAG_W'(TAG_INVALID);
      val2_s = tbl_arch_s[1];
    end else begin
      tag2_s = tbl_tag_s[1];
    end
  end

  // Dispatch register: load on fire, otherwise keep snooping broadcasts
  always_comb begin
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_unit_d   = out_unit_q;
    out_tag1_d   = out_tag1_q;
    out_tag2_d   = out_tag2_q;
    out_val1_d   = out_val1_q;
    out_val2_d   = out_val2_q;
    out_target_d = out_target_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (dispatch_s) begin
      out_valid_d  = 1'b1;
      out_op_d     = in_op;
      out_unit_d   = in_unit;
      out_tag1_d   = tag1_s;
      out_tag2_d   = tag2_s;
      out_val1_d   = val1_s;
      out_val2_d   = val2_s;
      out_target_d = rob_tag;
    end else if (fire_s) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && (out_tag1_q != TAG_W'(TAG_INVALID)) &&
            (wb_tag[p*TAG_W +: TAG_W] == out_tag1_q)) begin
          out_tag1_d = TAG_W'(TAG_INVALID);
          out_val1_d = wb_val[p*XLEN +: XLEN];
        end else begin
          out_tag1_d = out_tag1_d;
        end
        if (wb_valid[p] && (out_tag2_q != TAG_W'(TAG_INVALID)) &&
            (wb_tag[p*TAG_W +: TAG_W] == out_tag2_q)) begin
          out_tag2_d = TAG_W'(TAG_INVALID);
          out_val2_d = wb_val[p*XLEN +: XLEN];
        end else begin
          out_tag2_d = out_tag2_d;
        end
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Output state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_unit_q   <= '0;
      out_tag1_q   <= '0;
      out_tag2_q   <= '0;
      out_val1_q   <= '0;
      out_val2_q   <= '0;
      out_target_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_unit_q   <= out_unit_d;
      out_tag1_q   <= out_tag1_d;
      out_tag2_q   <= out_tag2_d;
      out_val1_q   <= out_val1_d;
      out_val2_q   <= out_val2_d;
      out_target_q <= out_target_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_unit   = out_unit_q;
  assign out_tag1   = out_tag1_q;
  assign out_tag2   = out_tag2_q;
  assign out_val1   = out_val1_q;
  assign out_val2   = out_val2_q;
  assign out_target = out_target_q;

endmodule

// File: tb/tb_id_rename.sv
// Scoreboard bench for id_rename: a small table model predicts each dispatch
// when the instruction is driven; the prediction is compared one cycle later.
module tb_id_rename;
  import scipio_pkg::*;

  localparam int XLEN = 32, NREG = 32, TAG_W = 4, WB_PORTS = 2, RW = 5;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [UNIT_W-1:0] unit;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [XLEN-1:0]   val1;
    logic [XLEN-1:0]   val2;
    logic [TAG_W-1:0]  target;
  } disp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm;
  logic [OP_W-1:0] in_op;
  logic [UNIT_W-1:0] in_unit;
  logic [RW-1:0] in_rs1, in_rs2, in_rd;
  logic in_rs1_en, in_rs2_en, in_rd_en, in_imm_en, in_pc_en;
  logic rob_ready, rob_alloc;
  logic [TAG_W-1:0] rob_tag;
  logic [WB_PORTS-1:0] wb_valid;
  logic [WB_PORTS*TAG_W-1:0] wb_tag;
  logic [WB_PORTS*XLEN-1:0] wb_val;
  logic cm_valid;
  logic [RW-1:0] cm_rd;
  logic [TAG_W-1:0] cm_tag;
  logic [XLEN-1:0] cm_val;
  logic [NUM_UNITS-1:0] rs_full;
  logic out_valid;
  logic [OP_W-1:0] out_op;
  logic [UNIT_W-1:0] out_unit;
  logic [TAG_W-1:0] out_tag1, out_tag2, out_target;
  logic [XLEN-1:0] out_val1, out_val2;

  id_rename #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .WB_PORTS(WB_PORTS)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_op(in_op), .in_unit(in_unit),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rd_en(in_rd_en),
    .in_imm_en(in_imm_en), .in_pc_en(in_pc_en),
    .rob_ready(rob_ready), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .rs_full(rs_full), .out_valid(out_valid), .out_op(out_op), .out_unit(out_unit),
    .out_tag1(out_tag1), .out_tag2(out_tag2), .out_val1(out_val1), .out_val2(out_val2),
    .out_target(out_target)
  );

  disp_t sb[$];
  logic [TAG_W-1:0] m_tag [NREG];
  logic [XLEN-1:0]  m_arch [NREG];
  logic exp_ren;
  int n_tests = 0;
  int n_fail = 0;

  // Reference lookup of one source operand from the model table
  function automatic void pred_src(input logic sel, input logic [XLEN-1:0] sel_val,
                                   input logic en, input logic [RW-1:0] rs,
                                   output logic [TAG_W-1:0] t, output logic [XLEN-1:0] v);
    t = 4'd0;
    v = 32'd0;
    if (sel) v = sel_val;
    else if (!en || rs == 5'd0) v = m_arch[rs];
    else if (m_tag[rs] == 4'd0) v = m_arch[rs];
    else if (wb_valid[0] && wb_tag[3:0] == m_tag[rs]) v = wb_val[31:0];
    else if (wb_valid[1] && wb_tag[7:4] == m_tag[rs]) v = wb_val[63:32];
    else if (cm_valid && cm_rd == rs && cm_tag == m_tag[rs]) v = cm_val;
    else t = m_tag[rs];
  endfunction

  // Waiting operands have no defined value, so it is masked out
  function automatic disp_t sample_out();
    disp_t d;
    d.op = out_op;
    d.unit = out_unit;
    d.tag1 = out_tag1;
    d.tag2 = out_tag2;
    d.val1 = (out_tag1 != 4'd0) ? 32'd0 : out_val1;
    d.val2 = (out_tag2 != 4'd0) ? 32'd0 : out_val2;
    d.target = out_target;
    return d;
  endfunction

  task automatic send(input logic [3:0] op, input logic [1:0] unit,
                      input logic [4:0] rs1, input logic rs1_en,
                      input logic [4:0] rs2, input logic rs2_en,
                      input logic [4:0] rd, input logic rd_en,
                      input logic pc_en, input logic imm_en,
                      input logic [3:0] tag, input logic fires);
    disp_t e;
    logic [TAG_W-1:0] t;
    logic [XLEN-1:0] v;
    in_valid = 1'b1; in_op = op; in_unit = unit;
    in_rs1 = rs1; in_rs1_en = rs1_en; in_rs2 = rs2; in_rs2_en = rs2_en;
    in_rd = rd; in_rd_en = rd_en; in_pc_en = pc_en; in_imm_en = imm_en; rob_tag = tag;
    if (fires && unit != EX_ERR_UNIT) begin
      e.op = op; e.unit = unit; e.target = tag;
      pred_src(pc_en, in_pc, rs1_en, rs1, t, v); e.tag1 = t; e.val1 = v;
      pred_src(imm_en, in_imm, rs2_en, rs2, t, v); e.tag2 = t; e.val2 = v;
      sb.push_back(e);
      exp_ren = rd_en && (rd != 5'd0);
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin m_tag[i] = 4'd0; m_arch[i] = 32'd0; end
      sb.delete();
    end else begin
      if (cm_valid && cm_rd != 5'd0) begin
        m_arch[cm_rd] = cm_val;
        if (m_tag[cm_rd] == cm_tag && !(exp_ren && in_rd == cm_rd)) m_tag[cm_rd] = 4'd0;
      end
      if (flush) for (int i = 0; i < NREG; i++) m_tag[i] = 4'd0;
      else if (exp_ren) m_tag[in_rd] = rob_tag;
    end
    #1;
    in_valid = 1'b0; wb_valid = 2'b00; cm_valid = 1'b0; flush = 1'b0; exp_ren = 1'b0;
  endtask

  task automatic test_reset();
    disp_t e, g;
    rst = 1'b0;
    send(4'h1, 2'd0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    tick(); tick();
    in_valid = 1'b1; #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || rob_alloc !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: out_valid=%b in_ready=%b rob_alloc=%b, want 0 0 0", out_valid, in_ready, rob_alloc);
    end
    in_valid = 1'b0; rst = 1'b1;
    cm_valid = 1'b1; cm_rd = 5'd7; cm_tag = 4'd2; cm_val = 32'h55;
    send(4'h1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
    n_tests++;
    if (rob_alloc !== 1'b1) begin n_fail++; $display("FAIL reset_first_alloc: rob_alloc=%b want 1", rob_alloc); end
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (out_valid !== 1'b1 || g !== e) begin n_fail++; $display("FAIL reset_first_disp: got %h want %h", g, e); end
    rst = 1'b0;
    send(4'h2, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0 || rob_alloc !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_ready: in_ready=%b rob_alloc=%b want 0 0", in_ready, rob_alloc);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_target !== 4'd0) begin
      n_fail++; $display("FAIL reset_mid_drop: out_valid=%b target=%h want 0 0", out_valid, out_target);
    end
    rst = 1'b1;
    for (int i = 0; i < NREG / 2; i++) begin
      send(4'h3, 2'd1, 5'(2*i), 1'b1, 5'(2*i+1), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
      tick();
      n_tests++; e = sb.pop_front(); g = sample_out();
      if (out_valid !== 1'b1 || g !== e || out_tag1 !== 4'd0 || out_tag2 !== 4'd0 || out_val1 !== 32'd0 || out_val2 !== 32'd0) begin
        n_fail++; $display("FAIL reset_table_r%0d: got %h want %h", 2*i, g, e);
      end
    end
  endtask

  task automatic test_rename_wb();
    disp_t e, g;
    send(4'h1, 2'd0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
    n_tests++;
    if (in_ready !== 1'b1 || rob_alloc !== 1'b1) begin
      n_fail++; $display("FAIL add_accept: in_ready=%b rob_alloc=%b want 1 1", in_ready, rob_alloc);
    end
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (out_valid !== 1'b1 || g !== e) begin n_fail++; $display("FAIL add_disp: got %h want %h", g, e); end
    send(4'h2, 2'd1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_tag1 !== 4'd3) begin n_fail++; $display("FAIL read_busy: got %h want %h (tag1 3)", g, e); end
    wb_valid = 2'b01; wb_tag = 8'h03; wb_val = {32'h0, 32'h2A};
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_tag1 !== 4'd0 || out_val1 !== 32'h2A) begin
      n_fail++; $display("FAIL wb_resolve: valid=%b tag1=%h val1=%h want 1 0 2a", out_valid, out_tag1, out_val1);
    end
  endtask

  task automatic test_bypass();
    disp_t e, g;
    wb_valid = 2'b10; wb_tag = 8'h30; wb_val = {32'h11, 32'h0};
    send(4'h3, 2'd2, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_tag1 !== 4'd0 || out_val1 !== 32'h11 || out_val2 !== 32'hFFFF_FFF0) begin
      n_fail++; $display("FAIL same_cycle_bypass: got %h want %h", g, e);
    end
  endtask

  task automatic test_stall();
    disp_t prev;
    prev = sample_out();
    for (int k = 0; k < 3; k++) begin
      rob_ready = (k != 0);
      rs_full = (k == 1) ? 4'b0001 : ((k == 2) ? 4'b0100 : 4'b0000);
      send(4'h4, (k == 2) ? 2'd1 : 2'd0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0);
      n_tests++;
      if (in_ready !== 1'b0 || rob_alloc !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready_%0d: in_ready=%b rob_alloc=%b want 0 0", k, in_ready, rob_alloc);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || sample_out() !== prev) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %h want %h", k, sample_out(), prev);
      end
    end
    rob_ready = 1'b1; rs_full = 4'b0000;
  endtask

  task automatic test_commit_rename();
    disp_t e, g;
    cm_valid = 1'b1; cm_rd = 5'd5; cm_tag = 4'd3; cm_val = 32'h00C0_FFEE;
    send(4'h5, 2'd0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_val1 !== 32'h00C0_FFEE) begin n_fail++; $display("FAIL commit_fwd: got %h want %h", g, e); end
    send(4'h6, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_tag1 !== 4'd7) begin n_fail++; $display("FAIL rename_wins: got %h want %h (tag1 7)", g, e); end
  endtask

  task automatic test_flush();
    disp_t e, g;
    send(4'h7, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e) begin n_fail++; $display("FAIL pre_flush: got %h want %h", g, e); end
    flush = 1'b1;
    send(4'h7, 2'd1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 4'd10, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0 || rob_alloc !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: in_ready=%b rob_alloc=%b want 0 0", in_ready, rob_alloc);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: out_valid=%b want 0", out_valid); end
    send(4'h8, 2'd0, 5'd5, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_tag1 !== 4'd0 || out_tag2 !== 4'd0 || out_val1 !== 32'h00C0_FFEE) begin
      n_fail++; $display("FAIL flush_lookup: got %h want %h", g, e);
    end
  endtask

  task automatic test_err_unit();
    disp_t e, g;
    send(4'h9, EX_ERR_UNIT, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1);
    n_tests++;
    if (in_ready !== 1'b1 || rob_alloc !== 1'b0) begin
      n_fail++; $display("FAIL err_consume: in_ready=%b rob_alloc=%b want 1 0", in_ready, rob_alloc);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_dispatch: out_valid=%b want 0", out_valid); end
    send(4'hA, 2'd2, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_tag1 !== 4'd0) begin n_fail++; $display("FAIL err_no_rename: got %h want %h", g, e); end
  endtask

  task automatic test_back_to_back();
    disp_t e, g;
    send(4'hB, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e) begin n_fail++; $display("FAIL b2b_0: got %h want %h", g, e); end
    send(4'hC, 2'd1, 5'd3, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_val1 !== 32'h0000_1000 || out_tag2 !== 4'd1) begin n_fail++; $display("FAIL b2b_1: got %h want %h", g, e); end
    wb_valid = 2'b01; wb_tag = 8'h01; wb_val = {32'h0, 32'h1234};
    send(4'hD, 2'd2, 5'd11, 1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
    tick();
    n_tests++; e = sb.pop_front(); g = sample_out();
    if (g !== e || out_tag1 !== 4'd2 || out_val2 !== 32'h1234) begin n_fail++; $display("FAIL b2b_2: got %h want %h", g, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; exp_ren = 1'b0;
    in_pc = 32'h0000_1000; in_imm = 32'hFFFF_FFF0;
    in_op = 4'd0; in_unit = 2'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_rs1_en = 1'b0; in_rs2_en = 1'b0; in_rd_en = 1'b0; in_imm_en = 1'b0; in_pc_en = 1'b0;
    rob_ready = 1'b1; rob_tag = 4'd1; rs_full = 4'b0000;
    wb_valid = 2'b00; wb_tag = 8'h00; wb_val = 64'h0;
    cm_valid = 1'b0; cm_rd = 5'd0; cm_tag = 4'd0; cm_val = 32'd0;
    for (int i = 0; i < NREG; i++) begin m_tag[i] = 4'd0; m_arch[i] = 32'd0; end
    test_reset();
    test_rename_wb();
    test_bypass();
    test_stall();
    test_commit_rename();
    test_flush();
    test_err_unit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
